// File: rtl/sdspi_pkg.sv
// Shared constants and state encodings for the SD sector reader.
package sdspi_pkg;

    // SD controller register map (APB byte offsets)
    localparam logic [15:0] SECT_REG = 16'h0000;
    localparam logic [15:0] CMD_REG  = 16'h0004;
    localparam logic [15:0] STAT_REG = 16'h0008;
    localparam logic [15:0] DATA_REG = 16'h000C;

    localparam logic [31:0] CMD_READ = 32'h0000_0001;

    // Status register bits
    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_ERR_BIT  = 1;

    // err_code values
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SLVERR  = 2'd1;
    localparam logic [1:0] ERR_STATUS  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // One 512-byte sector as 32-bit words
    localparam int unsigned WORDS      = 128;
    localparam logic [6:0]  LAST_INDEX = 7'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SECT,
        S_WR_CMD,
        S_POLL,
        S_RD_DATA,
        S_PUSH,
        S_FIN,
        S_FAIL
    } state_t;

    typedef enum logic [1:0] {
        X_IDLE,
        X_SETUP,
        X_ACCESS
    } xfer_state_t;

endpackage

// File: rtl/sdspi_sector_reader_if.sv
// APB bus between the sector reader (master) and the SD controller (slave).
interface sdspi_sector_reader_if;
    logic        m_psel;
    logic        m_penable;
    logic        m_pwrite;
    logic [15:0] m_paddr;
    logic [31:0] m_pwdata;
    logic [31:0] m_prdata;
    logic        m_pready;
    logic        m_pslverr;

    modport master (
        output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
        input  m_prdata, m_pready, m_pslverr
    );

    modport slave (
        input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
        output m_prdata, m_pready, m_pslverr
    );
endinterface

// File: rtl/sdspi_apb_xfer.sv
// Single-transfer APB master: one setup cycle, access until pready, then idle.
// done/rdata/slverr are valid in the pready cycle itself.
module sdspi_apb_xfer
    import sdspi_pkg::*;
(
    input  logic        clk27mhz,
    input  logic        resetn,
    input  logic        start,
    input  logic        write,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic        idle,
    output logic        done,
    output logic [31:0] rdata,
    output logic        slverr,
    sdspi_sector_reader_if.master apb
);

    xfer_state_t xs;

    assign idle   = (xs == X_IDLE);
    assign done   = (xs == X_ACCESS) && apb.m_pready;
    assign rdata  = apb.m_prdata;
    assign slverr = apb.m_pslverr;

    // Transfer phase sequencing; bus outputs are registered and held stable
    always_ff @(posedge clk27mhz or negedge resetn) begin
        if (!resetn) begin
            xs            <= X_IDLE;
            apb.m_psel    <= 1'b0;
            apb.m_penable <= 1'b0;
            apb.m_pwrite  <= 1'b0;
            apb.m_paddr   <= '0;
            apb.m_pwdata  <= '0;
        end else begin
            case (xs)
                X_IDLE: if (start) begin
                    xs            <= X_SETUP;
                    apb.m_psel    <= 1'b1;
                    apb.m_penable <= 1'b0;
                    apb.m_pwrite  <= write;
                    apb.m_paddr   <= addr;
                    apb.m_pwdata  <= wdata;
                end
                X_SETUP: begin
                    xs            <= X_ACCESS;
                    apb.m_penable <= 1'b1;
                end
                X_ACCESS: if (apb.m_pready) begin
                    xs            <= X_IDLE;
                    apb.m_psel    <= 1'b0;
                    apb.m_penable <= 1'b0;
                end
                default: xs <= X_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sdspi_sector_reader.sv
// Reads one 512-byte sector from the SD controller over APB and streams it
// out as 128 words through a valid/ready handshake.
module sdspi_sector_reader
    import sdspi_pkg::*;
#(
    parameter int unsigned POLL_TIMEOUT = 2_700_000
) (
    input  logic        clk27mhz,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_sector,
    sdspi_sector_reader_if.master apb,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [31:0] wr_data,
    output logic [6:0]  wr_index,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam logic [21:0] TIMEOUT_LIM = 22'(POLL_TIMEOUT);

    state_t      state;
    logic [31:0] sector;
    logic [21:0] poll_cnt;

    logic        bus_state, timed_out, fail_now;
    logic [1:0]  fail_code;
    logic        x_start, x_write, x_idle, x_done, x_slverr;
    logic [15:0] x_addr;
    logic [31:0] x_wdata, x_rdata;

    sdspi_apb_xfer u_xfer (
        .clk27mhz (clk27mhz),
        .resetn   (resetn),
        .start    (x_start),
        .write    (x_write),
        .addr     (x_addr),
        .wdata    (x_wdata),
        .idle     (x_idle),
        .done     (x_done),
        .rdata    (x_rdata),
        .slverr   (x_slverr),
        .apb      (apb)
    );

    // Per-state bus request and error detection (slverr, then status error, then timeout)
    always_comb begin
        bus_state = 1'b0;
        x_write   = 1'b0;
        x_addr    = '0;
        x_wdata   = '0;
        case (state)
            S_WR_SECT: begin bus_state = 1'b1; x_write = 1'b1; x_addr = SECT_REG; x_wdata = sector;   end
            S_WR_CMD:  begin bus_state = 1'b1; x_write = 1'b1; x_addr = CMD_REG;  x_wdata = CMD_READ; end
            S_POLL:    begin bus_state = 1'b1; x_addr = STAT_REG; end
            S_RD_DATA: begin bus_state = 1'b1; x_addr = DATA_REG; end
            default:   ;
        endcase

        timed_out = (state == S_POLL) && (poll_cnt >= TIMEOUT_LIM);
        x_start   = bus_state && x_idle && !timed_out;

        fail_now  = 1'b0;
        fail_code = ERR_NONE;
        if (bus_state && x_done) begin
            if (x_slverr) begin
                fail_now = 1'b1; fail_code = ERR_SLVERR;
            end else if ((state == S_POLL) && x_rdata[STAT_ERR_BIT]) begin
                fail_now = 1'b1; fail_code = ERR_STATUS;
            end else if (timed_out) begin
                fail_now = 1'b1; fail_code = ERR_TIMEOUT;
            end
        end else if (timed_out && x_idle) begin
            fail_now = 1'b1; fail_code = ERR_TIMEOUT;
        end
    end

    // Sector sequencer; done/err are set on entry so they pulse during FIN/FAIL
    always_ff @(posedge clk27mhz or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            sector    <= '0;
            poll_cnt  <= '0;
            wr_valid  <= 1'b0;
            wr_data   <= '0;
            wr_index  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (fail_now) begin
                state    <= S_FAIL;
                err      <= 1'b1;
                err_code <= fail_code;
                wr_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (req_valid) begin
                        sector    <= req_sector;
                        err_code  <= ERR_NONE;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_WR_SECT;
                    end
                    S_WR_SECT: if (x_done) state <= S_WR_CMD;
                    S_WR_CMD: if (x_done) begin
                        poll_cnt <= '0;
                        state    <= S_POLL;
                    end
                    S_POLL: begin
                        if (!timed_out) poll_cnt <= poll_cnt + 22'd1;
                        if (x_done && !x_rdata[STAT_BUSY_BIT]) state <= S_RD_DATA;
                    end
                    S_RD_DATA: if (x_done) begin
                        wr_data  <= x_rdata;
                        wr_valid <= 1'b1;
                        state    <= S_PUSH;
                    end
                    S_PUSH: if (wr_ready) begin
                        wr_valid <= 1'b0;
                        if (wr_index == LAST_INDEX) begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            wr_index <= wr_index + 7'd1;
                            state    <= S_RD_DATA;
                        end
                    end
                    S_FIN, S_FAIL: begin
                        wr_index  <= '0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdspi_sector_reader.sv
// Directed bench for sdspi_sector_reader with a behavioural SD controller
// slave and scoreboards for APB transfers and delivered words.
module tb_sdspi_sector_reader;
    import sdspi_pkg::*;

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [31:0] d;
    } apb_exp_t;

    typedef struct {
        logic [31:0] d;
        logic [6:0]  i;
    } word_exp_t;

    logic        clk27mhz = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_sector = '0;
    logic        wr_ready = 1'b1;
    logic        req_ready, wr_valid, done, err, busy;
    logic [31:0] wr_data;
    logic [6:0]  wr_index;
    logic [1:0]  err_code;

    sdspi_sector_reader_if apb_if ();

    sdspi_sector_reader #(.POLL_TIMEOUT(100)) dut (
        .clk27mhz   (clk27mhz),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sector (req_sector),
        .apb        (apb_if.master),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_index   (wr_index),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .busy       (busy)
    );

    always #5 clk27mhz = ~clk27mhz;

    int n_vec = 0;
    int n_miss = 0;

    apb_exp_t  exp_apb[$];
    word_exp_t exp_word[$];

    // slave model knobs
    int          stat_busy_n = 0, stat_cnt = 0, data_idx = 0;
    logic [31:0] stat_final = '0;
    bit          inj_en = 1'b0, stat_wild = 1'b0;
    logic [15:0] inj_addr = '0;
    int          stall_idx = 3, stall_left = 0, stall_seen = 0;

    // observations
    int          cyc = 0, cmd_cyc = 0, err_cyc = 0;
    int          done_cnt = 0, err_cnt = 0, words_seen = 0, psel_len = 0;
    logic        prev_psel = 1'b0;
    logic [15:0] setup_addr = '0;
    logic [31:0] setup_wdata = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave responses, APB protocol checks, word sink and pulse counting
    always @(negedge clk27mhz) begin
        apb_exp_t  ea;
        word_exp_t ew;
        cyc++;

        if (wr_valid && int'(wr_index) == stall_idx && stall_left > 0) begin
            wr_ready = 1'b0;
            stall_left--;
            stall_seen++;
        end else begin
            wr_ready = 1'b1;
        end

        if (!apb_if.m_psel) begin
            psel_len = 0;
            apb_if.m_pslverr = 1'b0;
            apb_if.m_prdata  = '0;
        end else begin
            psel_len++;
            if (!apb_if.m_penable) begin
                check("apb_idle_gap", 32'(prev_psel), 0);
                setup_addr  = apb_if.m_paddr;
                setup_wdata = apb_if.m_pwdata;
                apb_if.m_pslverr = inj_en && (apb_if.m_paddr == inj_addr);
                if (apb_if.m_paddr == STAT_REG)
                    apb_if.m_prdata = (stat_cnt < stat_busy_n) ? 32'h1 : stat_final;
                else if (apb_if.m_paddr == DATA_REG)
                    apb_if.m_prdata = 32'h1000 + data_idx;
                else
                    apb_if.m_prdata = '0;
            end else if (apb_if.m_pready) begin
                check("apb_len", 32'(psel_len), 2);
                check("apb_addr_stable", 32'(apb_if.m_paddr), 32'(setup_addr));
                if (apb_if.m_pwrite) check("apb_wdata_stable", apb_if.m_pwdata, setup_wdata);
                if (stat_wild && !apb_if.m_pwrite && apb_if.m_paddr == STAT_REG) begin
                    // polls during the timeout case are not individually scored
                end else if (exp_apb.size() == 0) begin
                    check("apb_unexpected", 32'(apb_if.m_paddr), 32'hFFFF_FFFF);
                end else begin
                    ea = exp_apb.pop_front();
                    check("apb_write", 32'(apb_if.m_pwrite), 32'(ea.w));
                    check("apb_addr", 32'(apb_if.m_paddr), 32'(ea.a));
                    if (ea.w) check("apb_wdata", apb_if.m_pwdata, ea.d);
                end
                if (apb_if.m_paddr == STAT_REG) stat_cnt++;
                if (apb_if.m_paddr == DATA_REG) data_idx++;
                if (apb_if.m_pwrite && apb_if.m_paddr == CMD_REG) cmd_cyc = cyc;
            end
        end
        prev_psel = apb_if.m_psel;

        if (wr_valid) begin
            check("push_no_apb", 32'(apb_if.m_psel), 0);
            if (!wr_ready) begin
                if (exp_word.size() > 0) begin
                    check("stall_data", wr_data, exp_word[0].d);
                    check("stall_index", 32'(wr_index), 32'(exp_word[0].i));
                end
            end else begin
                words_seen++;
                if (exp_word.size() == 0) begin
                    check("word_unexpected", 32'(wr_index), 32'hFFFF_FFFF);
                end else begin
                    ew = exp_word.pop_front();
                    check("word_data", wr_data, ew.d);
                    check("word_index", 32'(wr_index), 32'(ew.i));
                end
            end
        end
        if (done) done_cnt++;
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge clk27mhz);
        #1;
    endtask

    task automatic push_apb(input logic w, input logic [15:0] a, input logic [31:0] d);
        apb_exp_t e;
        e.w = w; e.a = a; e.d = d;
        exp_apb.push_back(e);
    endtask

    task automatic setup_model(input int busy_n, input logic [31:0] fin);
        stat_busy_n = busy_n;
        stat_final  = fin;
        stat_cnt    = 0;
        data_idx    = 0;
    endtask

    task automatic expect_sector(input logic [31:0] sec, input int busy_n);
        word_exp_t w;
        push_apb(1'b1, SECT_REG, sec);
        push_apb(1'b1, CMD_REG, CMD_READ);
        for (int i = 0; i <= busy_n; i++) push_apb(1'b0, STAT_REG, '0);
        for (int i = 0; i < 128; i++) begin
            push_apb(1'b0, DATA_REG, '0);
            w.d = 32'h1000 + i;
            w.i = 7'(i);
            exp_word.push_back(w);
        end
    endtask

    task automatic request(input logic [31:0] sec);
        req_sector = sec;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
        check("req_ready_busy", 32'(req_ready), 0);
        check("busy_high", 32'(busy), 1);
    endtask

    task automatic wait_end(input int budget, input string tag);
        int d0, e0, n;
        d0 = done_cnt; e0 = err_cnt; n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_bounded"}, 32'(n < budget), 1);
    endtask

    task automatic check_success(input string tag, input int d0, input int e0, input int w0);
        check({tag, "_done_once"}, 32'(done_cnt - d0), 1);
        check({tag, "_no_err"}, 32'(err_cnt - e0), 0);
        check({tag, "_words"}, 32'(words_seen - w0), 128);
        check({tag, "_apb_left"}, 32'(exp_apb.size()), 0);
        check({tag, "_words_left"}, 32'(exp_word.size()), 0);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 0);
        check({tag, "_req_ready"}, 32'(req_ready), 1);
        check({tag, "_busy_low"}, 32'(busy), 0);
        check({tag, "_index_clr"}, 32'(wr_index), 0);
    endtask

    initial begin
        int d0, e0, w0, n;

        apb_if.m_pready = 1'b1;
        resetn = 1'b0;
        repeat (3) tick();
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_psel", 32'(apb_if.m_psel), 0);
        check("rst_penable", 32'(apb_if.m_penable), 0);
        check("rst_wr_valid", 32'(wr_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_code", 32'(err_code), 0);
        check("rst_index", 32'(wr_index), 0);
        resetn = 1'b1;
        repeat (2) tick();

        // happy path: three busy polls, then data
        setup_model(3, 32'h0);
        expect_sector(32'h0000_0005, 3);
        d0 = done_cnt; e0 = err_cnt; w0 = words_seen;
        request(32'h0000_0005);
        wait_end(3000, "happy");
        check_success("happy", d0, e0, w0);

        // sink stalls ten cycles on word 3
        setup_model(0, 32'h0);
        stall_idx = 3; stall_left = 10; stall_seen = 0;
        expect_sector(32'h0000_0009, 0);
        d0 = done_cnt; e0 = err_cnt; w0 = words_seen;
        request(32'h0000_0009);
        wait_end(3000, "bp");
        check("bp_stall_cycles", 32'(stall_seen), 10);
        check_success("bp", d0, e0, w0);

        // slave error on the command write
        setup_model(0, 32'h0);
        inj_en = 1'b1; inj_addr = CMD_REG;
        push_apb(1'b1, SECT_REG, 32'h0000_0011);
        push_apb(1'b1, CMD_REG, CMD_READ);
        e0 = err_cnt; w0 = words_seen;
        request(32'h0000_0011);
        wait_end(200, "slverr");
        check("slverr_err_once", 32'(err_cnt - e0), 1);
        check("slverr_code", 32'(err_code), 1);
        tick();
        inj_en = 1'b0;
        check("slverr_req_ready", 32'(req_ready), 1);
        check("slverr_err_pulse", 32'(err), 0);
        check("slverr_code_held", 32'(err_code), 1);
        repeat (5) tick();
        check("slverr_apb_left", 32'(exp_apb.size()), 0);
        check("slverr_no_words", 32'(words_seen - w0), 0);

        // status error bit on the first poll
        setup_model(0, 32'h2);
        push_apb(1'b1, SECT_REG, 32'h0000_0012);
        push_apb(1'b1, CMD_REG, CMD_READ);
        push_apb(1'b0, STAT_REG, '0);
        e0 = err_cnt; w0 = words_seen;
        request(32'h0000_0012);
        check("code_cleared_on_accept", 32'(err_code), 0);
        wait_end(200, "staterr");
        check("staterr_err_once", 32'(err_cnt - e0), 1);
        check("staterr_code", 32'(err_code), 2);
        repeat (5) tick();
        check("staterr_apb_left", 32'(exp_apb.size()), 0);
        check("staterr_no_words", 32'(words_seen - w0), 0);

        // status stuck busy: timeout after 100 poll cycles
        setup_model(1_000_000, 32'h1);
        stat_wild = 1'b1;
        push_apb(1'b1, SECT_REG, 32'h0000_0022);
        push_apb(1'b1, CMD_REG, CMD_READ);
        e0 = err_cnt; w0 = words_seen;
        request(32'h0000_0022);
        wait_end(400, "timeout");
        check("timeout_err_once", 32'(err_cnt - e0), 1);
        check("timeout_code", 32'(err_code), 3);
        check("timeout_window", 32'(((err_cyc - cmd_cyc) >= 100) && ((err_cyc - cmd_cyc) <= 103)), 1);
        repeat (5) tick();
        stat_wild = 1'b0;
        check("timeout_apb_left", 32'(exp_apb.size()), 0);
        check("timeout_no_words", 32'(words_seen - w0), 0);

        // reset asserted while an access phase is stalled
        apb_if.m_pready = 1'b0;
        setup_model(0, 32'h0);
        push_apb(1'b1, SECT_REG, 32'h0000_0007);
        request(32'h0000_0007);
        n = 0;
        while (!(apb_if.m_psel && apb_if.m_penable) && n < 20) begin
            tick();
            n++;
        end
        check("rst_mid_reached_access", 32'(n < 20), 1);
        resetn = 1'b0;
        #1;
        check("rst_mid_psel", 32'(apb_if.m_psel), 0);
        check("rst_mid_penable", 32'(apb_if.m_penable), 0);
        check("rst_mid_wr_valid", 32'(wr_valid), 0);
        check("rst_mid_req_ready", 32'(req_ready), 1);
        check("rst_mid_busy", 32'(busy), 0);
        exp_apb.delete();
        exp_word.delete();
        repeat (2) tick();
        apb_if.m_pready = 1'b1;
        resetn = 1'b1;
        repeat (2) tick();
        setup_model(0, 32'h0);
        expect_sector(32'h0000_0007, 0);
        d0 = done_cnt; e0 = err_cnt; w0 = words_seen;
        request(32'h0000_0007);
        wait_end(3000, "after_rst");
        check_success("after_rst", d0, e0, w0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule

// File: doc/sdspi_sector_reader.md
Name: sdspi_sector_reader

Overview:
- APB-master sequencer that reads one 512-byte sector from the SD controller.
- Per request: programs sector address, issues READ, polls status, drains 128 data words through a valid/ready word stream.
- Replaces the ad-hoc start/done sector handshake feeding the boot RAM loader.
- Sits between the loader/boot FSM (request side, word sink) and the SD controller APB slave.

Parameters:
- SECT_REG, 16'h0000, APB offset of sector-address register
- CMD_REG, 16'h0004, APB offset of command register
- STAT_REG, 16'h0008, APB offset of status register (bit0 busy, bit1 error)
- DATA_REG, 16'h000C, APB offset of read-data FIFO (one 32-bit little-endian word per read)
- CMD_READ, 32'h0000_0001, value written to CMD_REG to start a read
- POLL_TIMEOUT, 2_700_000, cycles allowed in POLL (100 ms at 27 MHz); 22-bit counter
- WORDS, 128, words per sector

Ports:
- clk27mhz  in  1  sole clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  sector read request
- req_ready  out  1  high only in IDLE
- req_sector  in  32  sector number, captured on req_valid&&req_ready
- m_psel  out  1  APB select
- m_penable  out  1  APB enable
- m_pwrite  out  1  APB write
- m_paddr  out  16  APB address
- m_pwdata  out  32  APB write data
- m_prdata  in  32  APB read data
- m_pready  in  1  APB ready
- m_pslverr  in  1  APB slave error
- wr_valid  out  1  word available
- wr_ready  in  1  sink accepts word
- wr_data  out  32  sector word
- wr_index  out  7  word index within sector, 0..127
- done  out  1  one-cycle pulse, sector fully delivered
- err  out  1  one-cycle pulse, request aborted
- err_code  out  2  1 = pslverr, 2 = status error bit, 3 = poll timeout; held until next accepted request
- busy  out  1  high whenever not IDLE

Behaviour:
- Reset (async, immediate): all outputs 0 except req_ready = 1; state IDLE; counters 0; m_psel/m_penable drop at once, even mid-transfer.
- FSM: IDLE -> WR_SECT -> WR_CMD -> POLL -> RD_DATA -> PUSH -> (RD_DATA | FIN) -> IDLE. Any error -> FAIL -> IDLE.
- APB transfer (every bus state):
  - Setup cycle: psel = 1, penable = 0, paddr/pwrite/pwdata valid.
  - Access: psel = penable = 1 until pready.
  - Sample prdata/pslverr on the pready cycle; next cycle psel = penable = 0 (at least one idle cycle between transfers).
  - Addr/data stable across setup and access.
- WR_SECT: write req_sector to SECT_REG.
- WR_CMD: write CMD_READ to CMD_REG.
- POLL: repeated STAT_REG reads.
  - bit1 = 1 -> FAIL, code 2 (checked before busy).
  - bit0 = 0 -> RD_DATA.
  - Timeout counter clears on entering POLL and increments every POLL cycle; reaching POLL_TIMEOUT -> FAIL, code 3, finishing any in-flight transfer first.
- RD_DATA: read DATA_REG; on pready latch wr_data and go to PUSH.
- PUSH: wr_valid = 1, wr_data and wr_index stable until wr_valid&&wr_ready.
  - On handshake: wr_valid = 0; index < 127 -> index + 1, RD_DATA; index == 127 -> FIN.
  - No APB activity while PUSH waits (stall-safe, no buffering).
- FIN: done = 1 for one cycle, index = 0, IDLE.
- FAIL: err = 1 for one cycle; wr_valid = 0; index = 0; IDLE.
- pslverr = 1 on any pready cycle -> FAIL, code 1; prdata is discarded.
- req_valid while busy: ignored (req_ready = 0); requester holds request.
- pready held high constantly: each transfer takes exactly 2 cycles.

Decomposition:
- Package sdspi_pkg: register offsets, CMD_READ, status bit indices, err_code constants, FSM state enum.
- Sub-module sdspi_apb_xfer: single-transfer APB master.
  - Inputs: start, write, addr, wdata.
  - Outputs: done pulse, rdata, slverr.
  - Shared by all bus states.

Test Plan:
- Happy path: sector 0x0000_0005, status returns busy 3 times then 0, DATA_REG returns 0x1000+i, wr_ready = 1 -> writes 5 @0x0, 1 @0x4; exactly 128 words, wr_index 0..127 with data 0x1000..0x107F; done pulses once; pready = 1 gives 2-cycle transfers.
- Backpressure: wr_ready low 10 cycles on word 3 -> wr_data/wr_index frozen, no APB access while stalled, word 4 read only after handshake.
- pslverr on the WR_CMD access -> err pulse, err_code = 1, no status or data reads, req_ready = 1 next cycle.
- Status 0x2 on first poll -> err_code = 2, zero wr_valid.
- Status stuck at 0x1 with POLL_TIMEOUT overridden to 100 -> err within 100 + 2 cycles, err_code = 3.
- resetn low mid-access (psel = penable = 1) -> psel/penable/wr_valid 0 asynchronously; after release a new request for sector 7 completes normally.
